// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// ripple chunks, one chunk per stage, with a global-stall valid/ready handshake.
module pipelined_adder_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    logic              adv;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic              ovf_nx;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [CHUNK:0]    part [STAGES];

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + (CHUNK+1)'(c);
    endfunction

    // Global stall: every stage moves only when the output slot frees up
    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub | cin;
        s_in[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            part[k] = add_chunk(a_in[k][k*CHUNK +: CHUNK], b_in[k][k*CHUNK +: CHUNK], c_in[k]);
            c_nx[k] = part[k][CHUNK];
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end
        // Same-sign operands producing an opposite-sign result == carry-in(MSB) ^ carry-out(MSB)
        ovf_nx = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                 (s_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_in;
            c_q   <= c_nx;
            ovf_q <= ovf_nx;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub (WIDTH=16, STAGES=4): driver pushes
// expected results at accept time, an independent monitor pops on each output beat.
module tb_pipelined_adder_sub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;

    pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               t;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   rand_ready = 1'b0;
    logic [WIDTH+1:0] held;
    bit   held_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.t = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic on the mathematical meaning of each flag
    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                   input logic tc, input logic ts);
        exp_t e;
        int sa, sb, r;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (ts) begin
            r   = sa - sb;
            e.s = ta - tb_;
            e.c = (ta >= tb_);
        end else begin
            r   = sa + sb + int'(tc);
            e.s = ta + tb_ + WIDTH'(tc);
            e.c = (int'(ta) + int'(tb_) + int'(tc)) > 65535;
        end
        e.o = (r > 32767) || (r < -32768);
        e.t = 0;
        return e;
    endfunction

    // Downstream readiness: forced stall window, random, or always ready
    initial forever begin
        @(negedge clk);
        if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum 0x%0h with empty scoreboard (cycle %0d)", sum, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum", 32'(sum), 32'(e.s));
                    check("cout", 32'(cout), 32'(e.c));
                    check("ovf", 32'(ovf), 32'(e.o));
                    check("min_latency", 32'(cyc - e.t >= int'(STAGES)), 32'd1);
                    pop_cyc.push_back(cyc);
                end
            end
            if (out_valid && !out_ready) begin
                if (held_v) check("stall_stable", 32'({sum, cout, ovf}), 32'(held));
                held   = {sum, cout, ovf};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc, input logic ts, input exp_t e);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
            #1;
            if (in_ready) begin
                e.t = cyc;
                q.push_back(e);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    endtask

    task automatic send_rand(input bit edgy);
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;
        logic [WIDTH-1:0] corners [4];
        corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h7FFF; corners[3] = 16'h8000;
        ra = (edgy && $urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
        rb = (edgy && $urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            if (q.size() == 0 && !out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
    endtask

    task automatic check_latency();
        int n;
        for (n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'(STAGES));
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({cout, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Carry crossing a chunk boundary, with exact latency
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        check_latency();
        wait_drain();

        // Wrap-around, signed overflow, and subtraction ignoring cin
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        wait_drain();

        // Back-to-back stream
        n0 = pop_cyc.size();
        for (int i = 1; i <= 8; i++)
            send(WIDTH'(i), WIDTH'(16'h1000 * i), 1'b0, 1'b0, mk(WIDTH'(16'h1001 * i), 1'b0, 1'b0));
        wait_drain();
        check("stream_pops", 32'(pop_cyc.size() - n0), 32'd8);
        if (pop_cyc.size() - n0 == 8) check("stream_span", 32'(pop_cyc[n0+7] - pop_cyc[n0]), 32'd7);

        // Five-cycle backpressure with input held valid
        n0 = pop_cyc.size();
        stall_left = 5;
        for (int i = 0; i < 12; i++) send_rand(1'b0);
        wait_drain();
        check("stall_consumed", 32'(stall_left), 32'd0);
        check("stall_pops", 32'(pop_cyc.size() - n0), 32'd12);
        if (pop_cyc.size() - n0 == 12) check("stall_span", 32'(pop_cyc[n0+11] - pop_cyc[n0]), 32'd11);

        // Async reset with beats in flight
        for (int i = 0; i < 4; i++) send_rand(1'b0);
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum", 32'(sum), 32'd0);
        q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle(8);
        #3;
        check("no_stale", 32'(out_valid), 32'd0);
        send(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        check_latency();
        wait_drain();

        // Randomised traffic with random backpressure and input gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_rand(1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. It is the successor of the team's fixed 4-bit ripple-carry adder.
- The WIDTH-bit operation is split into STAGES ripple-carry chunks, one chunk per pipeline stage. The carry is registered between stages.
- A valid/ready handshake with backpressure is included.
- It sits in datapaths that need wide add/sub at full clock rate where a single-cycle ripple chain does not meet timing.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages and chunks. CHUNK = WIDTH/STAGES bits per stage. Range 1..WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB. For sub=1 this is the not-borrow flag: 1 iff a>=b unsigned.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst=1): all stage valid bits clear, all data/carry registers clear. out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 while rst=1 is de-asserted by the time of the first edge after release.
  - Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Advance condition: adv = !out_valid | out_ready.
  - This is a global stall: all stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv (combinational from out_valid and out_ready only; independent of in_valid).
- Accept: a beat is taken on a rising edge with in_valid & in_ready.
  - Stage 0 registers chunk 0 result and its carry.
  - Stage 0 also registers the not-yet-added upper chunks of a and b', where b' = sub ? ~b : b.
  - The effective carry-in is sub ? 1 : cin.
- Stage k (1..STAGES-1) adds chunk k of a and b' plus the registered carry from stage k-1. It forwards the completed lower chunks and the remaining operand chunks.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, when no stall occurs. With STAGES=1 the result is registered once (1-cycle latency).
- Throughput: 1 beat/cycle while out_ready=1.
- Bubbles: if in_valid=0 while adv=1, a bubble (valid=0) enters stage 0. Bubbles propagate and are not compressed.
- Backpressure: while out_valid=1 & out_ready=0, sum, cout and ovf hold stable, no stage changes and in_ready=0.
  - Simultaneous out_ready=1 and in_valid=1 on a full pipeline: the output is consumed and a new beat is accepted on the same edge.
- Per-stage registers: valid, carry, completed partial sum, and the carry into the MSB in the final stage, needed for ovf.
- Output flags are registered together with sum in the last stage and are meaningful only when out_valid=1.
- Wrap-around: sum is modulo 2^WIDTH and no saturation is applied. For example, 0xFFFF+0x0001 gives sum=0x0000, cout=1.
- Ordering: results emerge strictly in acceptance order.

Test Plan (WIDTH=16, STAGES=4):
- Reset, then accept a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0100, cout=0, ovf=0. The carry crosses the chunk 1 boundary.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (cin must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back beats (a=i, b=0x1000·i) with out_ready=1 -> 8 consecutive out_valid cycles with sum=0x1001·i, in order.
- Hold out_ready=0 for 5 cycles once out_valid=1 while in_valid=1 -> in_ready=0 and outputs stable during the stall. Release -> no beat is lost or duplicated, and the stream continues at 1/cycle.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately (async), no stale results after release, and a new beat yields the correct result after 4 cycles.
